// File: rtl/rst_req_ctrl_if.sv
// IO bus between the CPU register port and the reset-request controller.
// One strobe per access; the ack and read data follow one cycle later.
interface rst_req_ctrl_if;
   logic        stb;
   logic        we;
   logic        addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        ack;

   modport master (output stb, we, addr, data_in, input data_out, ack);
   modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/rst_req_ctrl.sv
// Reset-request source: merges button, soft and watchdog causes into one
// fixed-length rst_req pulse and keeps a sticky record of what fired.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | armed; any trigger is recorded and starts a request
//   ST_HOLD    | rst_req high, hold counter running down
//   ST_RELEASE | rst_req low, waiting for the debounced button to drop
module rst_req_ctrl #(
   parameter int unsigned WD_PRESCALE     = 50000,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_in,
   rst_req_ctrl_if.slave bus,
   output logic          rst_req
);

   localparam int PS_W   = $clog2(WD_PRESCALE + 1);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [PS_W-1:0]   PS_LAST     = PS_W'(WD_PRESCALE - 1);
   localparam logic [DB_W-1:0]   DB_RELOAD   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // Everything below this point up to the watchdog ignores rst on purpose:
   // the request has to survive the system reset it provokes.
   logic            btn_s1  = 1'b0;
   logic            btn_s2  = 1'b0;
   logic            btn_deb = 1'b0;
   logic [DB_W-1:0] deb_cnt = DB_RELOAD;

   logic [1:0]        state    = ST_IDLE;
   logic [HOLD_W-1:0] hold_cnt = '0;
   logic              req_q    = 1'b0;
   logic [3:0]        cause    = 4'b1000;
   logic [3:0]        cause_nxt;

   logic        wd_en;
   logic [15:0] wd_cnt;
   logic [PS_W-1:0] wd_pre;
   logic        wd_tick;

   logic        deb_flip;
   logic        btn_trig;
   logic        soft_trig;
   logic        wd_trig;
   logic [2:0]  trig_vec;

   logic        acc;
   logic        wr_ctrl;
   logic        wr_cause;
   logic        rd;
   logic [31:0] rd_data;
   logic        unused_data_in;

   assign deb_flip = (btn_s2 != btn_deb) && (deb_cnt == '0);
   assign btn_trig = deb_flip & btn_s2;

   always_ff @(posedge clk) begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      if ((btn_s2 == btn_deb) || deb_flip) begin
         deb_cnt <= DB_RELOAD;
      end else begin
         deb_cnt <= deb_cnt - 1'b1;
      end
      if (deb_flip) begin
         btn_deb <= btn_s2;
      end
   end

   assign acc      = bus.stb & ~rst;
   assign wr_ctrl  = acc & bus.we & ~bus.addr;
   assign wr_cause = acc & bus.we & bus.addr;
   assign rd       = acc & ~bus.we;
   assign rd_data  = bus.addr ? {28'b0, cause} : {wd_en, 15'b0, wd_cnt};
   assign unused_data_in = ^bus.data_in[30:16];

   assign soft_trig = wr_ctrl & bus.data_in[31];

   // A kick on the tick cycle reloads instead of decrementing, so it also
   // suppresses the timeout.
   assign wd_tick = wd_en && (wd_pre == PS_LAST);
   assign wd_trig = wd_tick && (wd_cnt == 16'd1) && !wr_ctrl && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_en  <= 1'b0;
         wd_cnt <= '0;
         wd_pre <= '0;
      end else if (wr_ctrl) begin
         wd_cnt <= bus.data_in[15:0];
         wd_en  <= |bus.data_in[15:0];
         wd_pre <= '0;
      end else if (wd_tick) begin
         wd_pre <= '0;
         wd_cnt <= wd_cnt - 16'd1;
         if (wd_cnt == 16'd1) begin
            wd_en <= 1'b0;
         end
      end else if (wd_en) begin
         wd_pre <= wd_pre + 1'b1;
      end
   end

   assign trig_vec = {wd_trig, soft_trig, btn_trig};

   // Set beats clear: the OR is applied after the write-1-to-clear mask.
   always_comb begin
      cause_nxt = cause;
      if (wr_cause) begin
         cause_nxt = cause & ~bus.data_in[3:0];
      end
      if (state == ST_IDLE) begin
         cause_nxt[2:0] = cause_nxt[2:0] | trig_vec;
      end
   end

   always_ff @(posedge clk) begin
      cause <= cause_nxt;
      case (state)
         ST_IDLE: begin
            if (|trig_vec) begin
               state    <= ST_HOLD;
               hold_cnt <= HOLD_RELOAD;
               req_q    <= 1'b1;
            end
         end
         ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state <= ST_RELEASE;
               req_q <= 1'b0;
            end else begin
               hold_cnt <= hold_cnt - 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!btn_deb) begin
               state <= ST_IDLE;
            end
         end
         default: begin
            state <= ST_IDLE;
            req_q <= 1'b0;
         end
      endcase
   end

   assign rst_req = req_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ack      <= 1'b0;
         bus.data_out <= '0;
      end else begin
         bus.ack      <= bus.stb;
         bus.data_out <= rd ? rd_data : 32'd0;
      end
   end

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl with small prescale/debounce constants;
// all expected values are hand-derived cycle counts and register images.
module tb_rst_req_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic rst_req;

   int n_chk = 0;
   int n_err = 0;
   int req_hi = 0;

   rst_req_ctrl_if bus ();

   rst_req_ctrl #(
      .WD_PRESCALE     (4),
      .DEBOUNCE_CYCLES (8),
      .HOLD_CYCLES     (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_in  (btn_in),
      .bus     (bus),
      .rst_req (rst_req)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_req === 1'b1) req_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic a, input logic [31:0] d);
      bus.stb = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
      tick();
      bus.stb = 1'b0; bus.we = 1'b0; bus.data_in = '0;
      chk("wr_ack", 32'(bus.ack), 32'd1);
   endtask

   task automatic bus_read(input logic a, output logic [31:0] d, output logic ak);
      bus.stb = 1'b1; bus.we = 1'b0; bus.addr = a; bus.data_in = '0;
      tick();
      bus.stb = 1'b0;
      d  = bus.data_out;
      ak = bus.ack;
   endtask

   task automatic wait_rise(input int max_cyc, output int d);
      d = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (rst_req === 1'b1) begin
            d = i;
            break;
         end
      end
   endtask

   task automatic pulse_width(output int w);
      w = 0;
      while (rst_req === 1'b1 && w < 200) begin
         w++;
         tick();
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        ak;
      int          d;
      int          w;
      int          base;

      bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_dout", bus.data_out, 32'd0);

      // power-up: quiet, CAUSE shows power-on only
      base = req_hi;
      repeat (1000) tick();
      chk("pwr_quiet", 32'(req_hi - base), 32'd0);
      bus_read(1'b1, rd, ak);
      chk("pwr_ack", 32'(ak), 32'd1);
      chk("pwr_cause", rd, 32'h8);
      tick();
      chk("ack_drop", 32'(bus.ack), 32'd0);
      chk("dout_drop", bus.data_out, 32'd0);
      bus_write(1'b1, 32'h8);
      bus_read(1'b1, rd, ak);
      chk("cause_clr", rd, 32'h0);

      // button: glitch ignored, real press gives one pulse
      base = req_hi;
      btn_in = 1'b1;
      repeat (5) tick();
      btn_in = 1'b0;
      repeat (30) tick();
      chk("glitch", 32'(req_hi - base), 32'd0);
      btn_in = 1'b1;
      wait_rise(40, d);
      chk("btn_delay", 32'(d), 32'd10);
      pulse_width(w);
      chk("btn_width", 32'(w), 32'd16);
      repeat (14) tick();
      base = req_hi;
      repeat (100) tick();
      chk("btn_held", 32'(req_hi - base), 32'd0);
      bus_read(1'b1, rd, ak);
      chk("btn_cause", rd, 32'h1);
      btn_in = 1'b0;
      repeat (20) tick();
      bus_write(1'b1, 32'hF);
      btn_in = 1'b1;
      wait_rise(40, d);
      chk("btn2_delay", 32'(d), 32'd10);
      pulse_width(w);
      chk("btn2_width", 32'(w), 32'd16);
      btn_in = 1'b0;
      repeat (30) tick();
      bus_read(1'b1, rd, ak);
      chk("btn2_cause", rd, 32'h1);
      bus_write(1'b1, 32'hF);

      // soft reset
      bus_write(1'b0, 32'h8000_0000);
      chk("soft_rise", 32'(rst_req), 32'd1);
      pulse_width(w);
      chk("soft_width", 32'(w), 32'd16);
      bus_read(1'b1, rd, ak);
      chk("soft_cause", rd, 32'h2);
      bus_read(1'b0, rd, ak);
      chk("soft_ctrl", rd, 32'h0);
      bus_write(1'b1, 32'hF);

      // watchdog timeout: 3 ticks of 4 cycles
      bus_write(1'b0, 32'h3);
      wait_rise(40, d);
      chk("wd_delay", 32'(d), 32'd12);
      pulse_width(w);
      chk("wd_width", 32'(w), 32'd16);
      bus_read(1'b1, rd, ak);
      chk("wd_cause", rd, 32'h4);
      bus_read(1'b0, rd, ak);
      chk("wd_ctrl", rd, 32'h0);
      bus_write(1'b1, 32'hF);
      tick();

      // regular kicks and a kick landing on the final tick
      base = req_hi;
      bus_write(1'b0, 32'h3);
      for (int k = 0; k < 25; k++) begin
         repeat (7) tick();
         bus_write(1'b0, 32'h3);
      end
      repeat (11) tick();
      bus_write(1'b0, 32'h3);
      bus_read(1'b0, rd, ak);
      chk("kick_ctrl", rd, 32'h8000_0003);
      bus_write(1'b0, 32'h0);
      repeat (20) tick();
      chk("kick_quiet", 32'(req_hi - base), 32'd0);
      bus_read(1'b1, rd, ak);
      chk("kick_cause", rd, 32'h0);

      // soft write on the debounced edge, then rst during HOLD
      base = req_hi;
      btn_in = 1'b1;
      repeat (9) tick();
      bus_write(1'b0, 32'h8000_0000);
      chk("both_rise", 32'(rst_req), 32'd1);
      bus_write(1'b0, 32'h0000_0100);
      rst = 1'b1;
      bus.stb = 1'b1; bus.we = 1'b0; bus.addr = 1'b0;
      tick();
      bus.stb = 1'b0;
      chk("rst_rd_ack", 32'(bus.ack), 32'd0);
      chk("rst_rd_dout", bus.data_out, 32'd0);
      repeat (9) tick();
      rst = 1'b0;
      bus_read(1'b0, rd, ak);
      chk("rst_ctrl_ack", 32'(ak), 32'd1);
      chk("rst_ctrl", rd, 32'h0);
      chk("hold_thru_rst", 32'(rst_req), 32'd1);
      repeat (40) tick();
      chk("both_width", 32'(req_hi - base), 32'd16);
      bus_read(1'b1, rd, ak);
      chk("both_cause", rd, 32'h3);
      btn_in = 1'b0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
